// File: rtl/s38417_tag_slot_bank.sv
// s38417_tag_slot_bank: three-slot tag store with a rotating one-hot slot
// selector, a combinational tag mux and a registered, holding match flag.
module s38417_tag_slot_bank #(
    parameter int TAG_W = 9,
    parameter int NSLOT = 3
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr,
    input  logic             adv,
    input  logic             cmp_en,
    input  logic [TAG_W-1:0] key,
    output logic [NSLOT-1:0] slot_sel,
    output logic [TAG_W-1:0] sel_tag,
    output logic [1:0]       count,
    output logic             match,
    output logic             match_vld
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [TAG_W-1:0] slot_r [NSLOT];
    logic [1:0]       count_r;
    logic [1:0]       wr_ptr_r;
    logic [NSLOT-1:0] sel_r;
    logic             match_r;
    logic             match_vld_r;
    logic             accept_s;
    logic             wr_ready_s;
    logic [TAG_W-1:0] sel_tag_s;

    // Rotate the one-hot select over the valid slots only; with fewer than
    // two valid slots there is nowhere to go, so the select holds.
    function automatic logic [NSLOT-1:0] next_sel(input logic [NSLOT-1:0] sel,
                                                 input logic [1:0]       cnt);
        logic [NSLOT-1:0] nxt;
        case (cnt)
            2'd2:    nxt = (sel == 3'b001) ? 3'b010 : 3'b001;
            2'd3:    nxt = {sel[1:0], sel[2]};
            default: nxt = sel;
        endcase
        return nxt;
    endfunction

    // Write handshake: a full bank or a flush in progress refuses writes.
    always_comb begin
        wr_ready_s = 1'b0;
        accept_s   = 1'b0;
        if ((state_r != FULL) && !clr) begin
            wr_ready_s = 1'b1;
            accept_s   = wr_valid;
        end else begin
            wr_ready_s = 1'b0;
            accept_s   = 1'b0;
        end
    end

    // Tag mux for the selected slot; a slot beyond the valid count reads as 0.
    always_comb begin
        sel_tag_s = {TAG_W{1'b0}};
        case (sel_r)
            3'b001:  sel_tag_s = (count_r > 2'd0) ? slot_r[0] : {TAG_W{1'b0}};
            3'b010:  sel_tag_s = (count_r > 2'd1) ? slot_r[1] : {TAG_W{1'b0}};
            3'b100:  sel_tag_s = (count_r > 2'd2) ? slot_r[2] : {TAG_W{1'b0}};
            default: sel_tag_s = {TAG_W{1'b0}};
        endcase
    end

    // Occupancy FSM: flush empties the bank, accepted writes fill it.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_r <= EMPTY;
        end else if (clr) begin
            state_r <= EMPTY;
        end else if (accept_s) begin
            case (state_r)
                EMPTY:   state_r <= PART;
                PART:    state_r <= (count_r == 2'd2) ? FULL : PART;
                FULL:    state_r <= FULL;
                default: state_r <= EMPTY;
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    // Slot storage, pointers, select and compare; clr overrides every other
    // event, and adv/compare both act on the values held before this edge.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_r[i] <= {TAG_W{1'b0}};
            end
            count_r     <= 2'd0;
            wr_ptr_r    <= 2'd0;
            sel_r       <= 3'b001;
            match_r     <= 1'b0;
            match_vld_r <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot_r[i] <= {TAG_W{1'b0}};
            end
            count_r     <= 2'd0;
            wr_ptr_r    <= 2'd0;
            sel_r       <= 3'b001;
            match_r     <= 1'b0;
            match_vld_r <= 1'b0;
        end else begin
            if (accept_s) begin
                for (int i = 0; i < NSLOT; i++) begin
                    if (wr_ptr_r == i[1:0]) begin
                        slot_r[i] <= wr_tag;
                    end
                end
                wr_ptr_r <= wr_ptr_r + 2'd1;
                count_r  <= count_r + 2'd1;
            end
            if (adv) begin
                sel_r <= next_sel(sel_r, count_r);
            end
            if (cmp_en) begin
                match_r     <= (count_r != 2'd0) && (key == sel_tag_s);
                match_vld_r <= 1'b1;
            end
        end
    end

    assign wr_ready  = wr_ready_s;
    assign slot_sel  = sel_r;
    assign sel_tag   = sel_tag_s;
    assign count     = count_r;
    assign match     = match_r;
    assign match_vld = match_vld_r;

endmodule

// File: tb/tb_s38417_tag_slot_bank.sv
// Directed table-driven bench for s38417_tag_slot_bank.
module tb_s38417_tag_slot_bank;

    logic       CK;
    logic       RN;
    logic       wr_valid;
    logic       wr_ready;
    logic [8:0] wr_tag;
    logic       clr;
    logic       adv;
    logic       cmp_en;
    logic [8:0] key;
    logic [2:0] slot_sel;
    logic [8:0] sel_tag;
    logic [1:0] count;
    logic       match;
    logic       match_vld;

    int n_checks;
    int n_fail;

    s38417_tag_slot_bank dut (
        .CK        (CK),
        .RN        (RN),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_tag    (wr_tag),
        .clr       (clr),
        .adv       (adv),
        .cmp_en    (cmp_en),
        .key       (key),
        .slot_sel  (slot_sel),
        .sel_tag   (sel_tag),
        .count     (count),
        .match     (match),
        .match_vld (match_vld)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic       clr;
        logic       wv;
        logic [8:0] tag;
        logic       adv;
        logic       cmp;
        logic [8:0] key;
        logic [2:0] e_sel;
        logic [8:0] e_tag;
        logic [1:0] e_cnt;
        logic       e_match;
        logic       e_vld;
        logic       e_rdy;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tagname, input logic [2:0] e_sel,
                             input logic [8:0] e_tag, input logic [1:0] e_cnt,
                             input logic e_match, input logic e_vld, input logic e_rdy);
        chk({tagname, ".slot_sel"},  {6'd0, slot_sel},  {6'd0, e_sel});
        chk({tagname, ".sel_tag"},   sel_tag,           e_tag);
        chk({tagname, ".count"},     {7'd0, count},     {7'd0, e_cnt});
        chk({tagname, ".match"},     {8'd0, match},     {8'd0, e_match});
        chk({tagname, ".match_vld"}, {8'd0, match_vld}, {8'd0, e_vld});
        chk({tagname, ".wr_ready"},  {8'd0, wr_ready},  {8'd0, e_rdy});
    endtask

    task automatic idle_inputs();
        clr      = 1'b0;
        wr_valid = 1'b0;
        wr_tag   = 9'h000;
        adv      = 1'b0;
        cmp_en   = 1'b0;
        key      = 9'h000;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RN       = 1'b0;
        idle_inputs();

        //            clr   wv    tag     adv   cmp   key     sel     tag     cnt   m     v     rdy
        vecs[0]  = '{1'b0, 1'b1, 9'h1A5, 1'b0, 1'b0, 9'h000, 3'b001, 9'h1A5, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 9'h03C, 1'b0, 1'b1, 9'h1A5, 3'b001, 9'h1A5, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b010, 9'h03C, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b001, 9'h1A5, 2'd2, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0, 9'h000, 3'b001, 9'h1A5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 9'h123, 1'b0, 1'b0, 9'h000, 3'b001, 9'h1A5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b010, 9'h03C, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b100, 9'h1FF, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b001, 9'h1A5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 3'b001, 9'h1A5, 2'd3, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h1A5, 3'b001, 9'h1A5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 9'h1FF, 3'b010, 9'h03C, 2'd3, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h03C, 3'b010, 9'h03C, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 9'h055, 1'b1, 1'b1, 9'h03C, 3'b001, 9'h000, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 3'b001, 9'h000, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 9'h0AA, 1'b0, 1'b0, 9'h000, 3'b001, 9'h0AA, 2'd1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 3'b001, 9'h0AA, 2'd1, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 9'h000, 1'b1, 1'b1, 9'h0AA, 3'b001, 9'h0AA, 2'd1, 1'b1, 1'b1, 1'b1};

        // Power-on reset state
        repeat (3) @(posedge CK);
        #1;
        check_all("reset", 3'b001, 9'h000, 2'd0, 1'b0, 1'b0, 1'b1);
        @(negedge CK);
        RN = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge CK);
            clr      = vecs[i].clr;
            wr_valid = vecs[i].wv;
            wr_tag   = vecs[i].tag;
            adv      = vecs[i].adv;
            cmp_en   = vecs[i].cmp;
            key      = vecs[i].key;
            @(posedge CK);
            #1;
            idle_inputs();
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_tag,
                      vecs[i].e_cnt, vecs[i].e_match, vecs[i].e_vld, vecs[i].e_rdy);
            // After vector 12 match=1: hold it with cmp_en low and a wrong key.
            if (i == 12) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge CK);
                    key = 9'h000;
                    @(posedge CK);
                    #1;
                    chk($sformatf("hold%0d.match", k), {8'd0, match}, 9'd1);
                end
                key = 9'h000;
            end
        end

        // Fill again, then reset mid-cycle: outputs must clear without a clock edge.
        @(negedge CK);
        wr_valid = 1'b1;
        wr_tag   = 9'h0F0;
        cmp_en   = 1'b1;
        key      = 9'h0AA;
        @(posedge CK);
        #1;
        idle_inputs();
        chk("prereset.count", {7'd0, count}, 9'd2);
        #2;
        RN = 1'b0;
        #1;
        check_all("midreset", 3'b001, 9'h000, 2'd0, 1'b0, 1'b0, 1'b1);
        @(negedge CK);
        RN = 1'b1;

        // Slots cleared: first write after reset lands in slot 0.
        @(negedge CK);
        wr_valid = 1'b1;
        wr_tag   = 9'h101;
        @(posedge CK);
        #1;
        idle_inputs();
        #1;
        check_all("postreset", 3'b001, 9'h101, 2'd1, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
